// File: rtl/decode_pkg.sv
// Shared opcodes, control-word layout and type definitions for the LEGv8 decode stage.
package decode_pkg;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_BR   = 11'b11010110000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [5:0]  OP_BL   = 6'b100101;

    localparam int unsigned CTRL_W         = 8;
    localparam int unsigned CTRL_REG_WRITE = 7;
    localparam int unsigned CTRL_MEM_READ  = 6;
    localparam int unsigned CTRL_MEM_TO_REG = 5;
    localparam int unsigned CTRL_MEM_WRITE = 4;
    localparam int unsigned CTRL_ALU_SRC   = 3;
    localparam int unsigned CTRL_LINK      = 2;
    localparam int unsigned CTRL_ALU_OP_LSB = 0;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_PASSB = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_e;

    typedef enum logic [3:0] {
        K_NONE, K_RTYPE, K_LDUR, K_STUR, K_ADDI, K_CBZ, K_CBNZ, K_B, K_BL, K_BR
    } op_kind_e;

    // Classify instruction[31:21]; shorter opcodes are matched on their leading bits.
    function automatic op_kind_e decode_op(input logic [10:0] op);
        op_kind_e k;
        k = K_NONE;
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) k = K_RTYPE;
        else if (op == OP_LDUR)      k = K_LDUR;
        else if (op == OP_STUR)      k = K_STUR;
        else if (op == OP_BR)        k = K_BR;
        else if (op[10:1] == OP_ADDI) k = K_ADDI;
        else if (op[10:3] == OP_CBZ)  k = K_CBZ;
        else if (op[10:3] == OP_CBNZ) k = K_CBNZ;
        else if (op[10:5] == OP_B)    k = K_B;
        else if (op[10:5] == OP_BL)   k = K_BL;
        return k;
    endfunction

endpackage

// File: rtl/decode_stage_pipe_regfile.sv
// Register file with combinational reads, hardwired-zero top register and optional
// WB write-through (DECODE_BYPASS_EN).
module decode_regfile
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned NREGS  = 32,
    localparam int unsigned REG_W = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_W-1:0]  raddr1,
    input  logic [REG_W-1:0]  raddr2,
    output logic [DATA_W-1:0] rdata1_c,
    output logic [DATA_W-1:0] rdata2_c
);

    localparam logic [REG_W-1:0] XZR = REG_W'(NREGS - 1);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && waddr != XZR) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1_c = (raddr1 == XZR) ? '0 : regs[raddr1];
        rdata2_c = (raddr2 == XZR) ? '0 : regs[raddr2];
`ifdef DECODE_BYPASS_EN
        if (we && waddr == raddr1 && raddr1 != XZR) rdata1_c = wdata;
        if (we && waddr == raddr2 && raddr2 != XZR) rdata2_c = wdata;
`endif
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// LEGv8 decode stage with ID/EX register, hazard stall FSM and early branch resolution.
// Optional WB write-through in the register file is enabled by DECODE_BYPASS_EN.
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned LINK_REG = 30,
    localparam int unsigned REG_W   = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              wb_en,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_W-1:0]  ex_rd,
    output logic              stall,
    output logic              flush,
    output logic [DATA_W-1:0] branch_target,
    output logic              idex_valid,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic [DATA_W-1:0] idex_rd1,
    output logic [DATA_W-1:0] idex_rd2,
    output logic [DATA_W-1:0] idex_imm,
    output logic [DATA_W-1:0] idex_pc,
    output logic [REG_W-1:0]  idex_rn,
    output logic [REG_W-1:0]  idex_rm,
    output logic [REG_W-1:0]  idex_rd
);

    localparam logic [REG_W-1:0] XZR = REG_W'(NREGS - 1);

    op_kind_e          kind;
    logic              reg2loc, uses_rn, uses_r2, is_cbr, id_valid, taken, src_match;
    logic [REG_W-1:0]  rn, r2, rd_idx;
    logic [DATA_W-1:0] rd1, rd2, imm;
    logic [CTRL_W-1:0] ctrl;
    logic [1:0]        need;
    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              squash_q, squash_d, issue;

    assign kind     = decode_op(instruction[31:21]);
    assign reg2loc  = kind inside {K_STUR, K_CBZ, K_CBNZ};
    assign uses_rn  = kind inside {K_RTYPE, K_LDUR, K_STUR, K_ADDI, K_BR};
    assign uses_r2  = kind inside {K_RTYPE, K_STUR, K_CBZ, K_CBNZ};
    assign is_cbr   = kind inside {K_CBZ, K_CBNZ, K_BR};
    assign id_valid = instr_valid && !squash_q && (kind != K_NONE);
    assign rn       = REG_W'(instruction[9:5]);
    assign r2       = reg2loc ? REG_W'(instruction[4:0]) : REG_W'(instruction[20:16]);
    assign rd_idx   = (kind == K_BL) ? REG_W'(LINK_REG) : REG_W'(instruction[4:0]);

    decode_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
        .clock    (clock),
        .reset    (reset),
        .we       (wb_en),
        .waddr    (wb_reg),
        .wdata    (wb_data),
        .raddr1   (rn),
        .raddr2   (r2),
        .rdata1_c (rd1),
        .rdata2_c (rd2)
    );

    // Control word and sign/zero-extended immediate per instruction class.
    always_comb begin
        ctrl = '0;
        imm  = '0;
        case (kind)
            K_RTYPE: begin
                ctrl[CTRL_REG_WRITE] = 1'b1;
                ctrl[CTRL_ALU_OP_LSB +: 2] = ALU_OP_FUNCT;
            end
            K_LDUR: begin
                ctrl[CTRL_REG_WRITE]  = 1'b1;
                ctrl[CTRL_MEM_READ]   = 1'b1;
                ctrl[CTRL_MEM_TO_REG] = 1'b1;
                ctrl[CTRL_ALU_SRC]    = 1'b1;
                ctrl[CTRL_ALU_OP_LSB +: 2] = ALU_OP_ADD;
                imm = {{(DATA_W-9){instruction[20]}}, instruction[20:12]};
            end
            K_STUR: begin
                ctrl[CTRL_MEM_WRITE] = 1'b1;
                ctrl[CTRL_ALU_SRC]   = 1'b1;
                ctrl[CTRL_ALU_OP_LSB +: 2] = ALU_OP_ADD;
                imm = {{(DATA_W-9){instruction[20]}}, instruction[20:12]};
            end
            K_ADDI: begin
                ctrl[CTRL_REG_WRITE] = 1'b1;
                ctrl[CTRL_ALU_SRC]   = 1'b1;
                ctrl[CTRL_ALU_OP_LSB +: 2] = ALU_OP_ADD;
                imm = {{(DATA_W-12){1'b0}}, instruction[21:10]};
            end
            K_CBZ, K_CBNZ: begin
                ctrl[CTRL_ALU_OP_LSB +: 2] = ALU_OP_PASSB;
                imm = {{(DATA_W-19){instruction[23]}}, instruction[23:5]};
            end
            K_B: imm = {{(DATA_W-26){instruction[25]}}, instruction[25:0]};
            K_BL: begin
                ctrl[CTRL_REG_WRITE] = 1'b1;
                ctrl[CTRL_LINK]      = 1'b1;
                imm = {{(DATA_W-26){instruction[25]}}, instruction[25:0]};
            end
            default: ;
        endcase
    end

    // Branch resolution and required stall depth for the instruction in ID.
    always_comb begin
        taken         = 1'b0;
        branch_target = pc_in + (imm << 2);
        case (kind)
            K_B, K_BL: taken = 1'b1;
            K_BR: begin
                taken         = 1'b1;
                branch_target = rd1;
            end
            K_CBZ:   taken = (rd2 == '0);
            K_CBNZ:  taken = (rd2 != '0);
            default: ;
        endcase

        src_match = (uses_rn && rn != XZR && rn == ex_rd) ||
                    (uses_r2 && r2 != XZR && r2 == ex_rd);
        need = 2'd0;
        if (id_valid && src_match) begin
            if (ex_memread)                need = is_cbr ? 2'd2 : 2'd1;
            else if (is_cbr && ex_regwrite) need = 2'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        squash_d = 1'b0;
        issue    = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (need != 2'd0) begin
                        stall = 1'b1;
                        if (need > 2'd1) begin
                            state_d = HOLD;
                            cnt_d   = need - 2'd1;
                        end
                    end else if (id_valid) begin
                        issue    = 1'b1;
                        flush    = taken;
                        squash_d = taken;
                    end
                end
                HOLD: begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_d == 2'd0) state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            squash_q <= squash_d;
        end
    end

    // ID/EX register; anything not issued becomes an all-zero bubble.
    always_ff @(posedge clock) begin
        if (reset || !issue) begin
            idex_valid <= 1'b0;
            idex_ctrl  <= '0;
            idex_rd1   <= '0;
            idex_rd2   <= '0;
            idex_imm   <= '0;
            idex_pc    <= '0;
            idex_rn    <= '0;
            idex_rm    <= '0;
            idex_rd    <= '0;
        end else begin
            idex_valid <= 1'b1;
            idex_ctrl  <= ctrl;
            idex_rd1   <= rd1;
            idex_rd2   <= rd2;
            idex_imm   <= imm;
            idex_pc    <= pc_in;
            idex_rn    <= rn;
            idex_rm    <= r2;
            idex_rd    <= rd_idx;
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed scoreboard bench for decode_stage_pipe (default parameters).
module tb_decode_stage_pipe;

    typedef struct packed {
        logic        valid;
        logic [7:0]  ctrl;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] imm;
        logic [63:0] pc;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [4:0]  rd;
    } idex_t;

    logic        clock = 1'b0;
    logic        reset, instr_valid, wb_en, ex_regwrite, ex_memread;
    logic [31:0] instruction;
    logic [63:0] pc_in, wb_data;
    logic [4:0]  wb_reg, ex_rd;
    logic        stall, flush, idex_valid;
    logic [63:0] branch_target, idex_rd1, idex_rd2, idex_imm, idex_pc;
    logic [7:0]  idex_ctrl;
    logic [4:0]  idex_rn, idex_rm, idex_rd;

    int    tests = 0;
    int    fails = 0;
    idex_t sb[$];

    always #5 clock = ~clock;

    decode_stage_pipe dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
        .pc_in(pc_in), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .stall(stall), .flush(flush), .branch_target(branch_target),
        .idex_valid(idex_valid), .idex_ctrl(idex_ctrl), .idex_rd1(idex_rd1),
        .idex_rd2(idex_rd2), .idex_imm(idex_imm), .idex_pc(idex_pc),
        .idex_rn(idex_rn), .idex_rm(idex_rm), .idex_rd(idex_rd)
    );

    function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rd, rn, rm);
        return {op, rm, 6'd0, rn, rd};
    endfunction
    function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] im, input logic [4:0] rn, rt);
        return {op, im, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] enc_cb(input logic [7:0] op, input logic [18:0] im, input logic [4:0] rt);
        return {op, im, rt};
    endfunction
    function automatic logic [31:0] enc_b(input logic [5:0] op, input logic [25:0] im);
        return {op, im};
    endfunction

    function automatic idex_t mk(input logic [7:0] c, input logic [63:0] a, b, im, pc,
                                 input logic [4:0] rn, rm, rd);
        return '{valid: 1'b1, ctrl: c, rd1: a, rd2: b, imm: im, pc: pc, rn: rn, rm: rm, rd: rd};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [31:0] ins, input logic [63:0] pc);
        instr_valid = v; instruction = ins; pc_in = pc;
    endtask
    task automatic set_ex(input logic rw, input logic mr, input logic [4:0] rd);
        ex_regwrite = rw; ex_memread = mr; ex_rd = rd;
    endtask
    task automatic set_wb(input logic en, input logic [4:0] r, input logic [63:0] d);
        wb_en = en; wb_reg = r; wb_data = d;
    endtask

    // One cycle: check combinational outputs mid-cycle, then the registered ID/EX fields.
    task automatic tick(input logic e_stall, input logic e_flush, input logic [63:0] e_bt, input idex_t e);
        idex_t x;
        @(negedge clock);
        chk("stall", 64'(stall), 64'(e_stall));
        chk("flush", 64'(flush), 64'(e_flush));
        if (e_flush) chk("branch_target", branch_target, e_bt);
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            tests++; fails++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            x = sb.pop_front();
            chk("idex_valid", 64'(idex_valid), 64'(x.valid));
            chk("idex_ctrl", 64'(idex_ctrl), 64'(x.ctrl));
            chk("idex_rd1", idex_rd1, x.rd1);
            chk("idex_rd2", idex_rd2, x.rd2);
            chk("idex_imm", idex_imm, x.imm);
            chk("idex_pc", idex_pc, x.pc);
            chk("idex_rn", 64'(idex_rn), 64'(x.rn));
            chk("idex_rm", 64'(idex_rm), 64'(x.rm));
            chk("idex_rd", 64'(idex_rd), 64'(x.rd));
        end
    endtask

    localparam logic [10:0] ADD  = 11'b10001011000;
    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] STUR = 11'b11111000000;
    localparam logic [7:0]  CBZ  = 8'b10110100;
    localparam logic [7:0]  CBNZ = 8'b10110101;
    localparam logic [5:0]  BOP  = 6'b000101;
    localparam logic [5:0]  BLOP = 6'b100101;

    initial begin
        idex_t bub;
        logic [63:0] byp;
        bub = '0;
`ifdef DECODE_BYPASS_EN
        byp = 64'hAA;
`else
        byp = 64'h11;
`endif
        // Reset held with a live hazard: no stall, bubbles out.
        reset = 1'b1;
        set_id(1'b1, enc_r(ADD, 5'd1, 5'd2, 5'd3), 64'h10);
        set_ex(1'b1, 1'b1, 5'd2);
        set_wb(1'b0, 5'd0, 64'd0);
        tick(1'b0, 1'b0, 64'd0, bub);
        tick(1'b0, 1'b0, 64'd0, bub);
        reset = 1'b0;
        set_ex(1'b0, 1'b0, 5'd0);
        set_id(1'b0, 32'd0, 64'd0);

        set_wb(1'b1, 5'd2, 64'd5);    tick(1'b0, 1'b0, 64'd0, bub);
        set_wb(1'b1, 5'd3, 64'd7);    tick(1'b0, 1'b0, 64'd0, bub);
        set_wb(1'b1, 5'd6, 64'h66);   tick(1'b0, 1'b0, 64'd0, bub);
        set_wb(1'b1, 5'd8, 64'h11);   tick(1'b0, 1'b0, 64'd0, bub);
        set_wb(1'b0, 5'd0, 64'd0);

        // ADD X1,X2,X3
        set_id(1'b1, enc_r(ADD, 5'd1, 5'd2, 5'd3), 64'h10);
        tick(1'b0, 1'b0, 64'd0, mk(8'h82, 64'd5, 64'd7, 64'd0, 64'h10, 5'd2, 5'd3, 5'd1));

        // Load-use: one stall, then issue
        set_id(1'b1, enc_r(ADD, 5'd5, 5'd4, 5'd6), 64'h14);
        set_ex(1'b1, 1'b1, 5'd4);
        tick(1'b1, 1'b0, 64'd0, bub);
        set_ex(1'b0, 1'b0, 5'd0);
        tick(1'b0, 1'b0, 64'd0, mk(8'h82, 64'd0, 64'h66, 64'd0, 64'h14, 5'd4, 5'd6, 5'd5));

        // CBZ X9 behind a load: two stalls, then taken to 0x10C, then squash
        set_id(1'b1, enc_cb(CBZ, 19'd3, 5'd9), 64'h100);
        set_ex(1'b1, 1'b1, 5'd9);
        tick(1'b1, 1'b0, 64'd0, bub);
        set_ex(1'b0, 1'b0, 5'd0);
        tick(1'b1, 1'b0, 64'd0, bub);
        tick(1'b0, 1'b1, 64'h10C, mk(8'h01, 64'd7, 64'd0, 64'd3, 64'h100, 5'd3, 5'd9, 5'd9));
        set_id(1'b1, enc_r(ADD, 5'd1, 5'd2, 5'd3), 64'h104);
        tick(1'b0, 1'b0, 64'd0, bub);

        // BL -2 at 0x40, then squash
        set_id(1'b1, enc_b(BLOP, 26'h3FFFFFE), 64'h40);
        tick(1'b0, 1'b1, 64'h38, mk(8'h84, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h40, 5'd31, 5'd31, 5'd30));
        set_id(1'b1, enc_r(ADD, 5'd1, 5'd2, 5'd3), 64'h44);
        tick(1'b0, 1'b0, 64'd0, bub);

        // WB write to X8 concurrent with a read of X8
        set_wb(1'b1, 5'd8, 64'hAA);
        set_id(1'b1, enc_r(ADD, 5'd7, 5'd8, 5'd2), 64'h50);
        tick(1'b0, 1'b0, 64'd0, mk(8'h82, byp, 64'd5, 64'd0, 64'h50, 5'd8, 5'd2, 5'd7));
        set_wb(1'b0, 5'd0, 64'd0);
        tick(1'b0, 1'b0, 64'd0, mk(8'h82, 64'hAA, 64'd5, 64'd0, 64'h50, 5'd8, 5'd2, 5'd7));

        // XZR write is discarded and reads as zero
        set_wb(1'b1, 5'd31, 64'h55);
        set_id(1'b1, enc_r(ADD, 5'd10, 5'd31, 5'd31), 64'h60);
        tick(1'b0, 1'b0, 64'd0, mk(8'h82, 64'd0, 64'd0, 64'd0, 64'h60, 5'd31, 5'd31, 5'd10));
        set_wb(1'b0, 5'd0, 64'd0);
        tick(1'b0, 1'b0, 64'd0, mk(8'h82, 64'd0, 64'd0, 64'd0, 64'h60, 5'd31, 5'd31, 5'd10));

        // CBNZ X2 behind an ALU producer: one stall, taken to 0x210
        set_id(1'b1, enc_cb(CBNZ, 19'd4, 5'd2), 64'h200);
        set_ex(1'b1, 1'b0, 5'd2);
        tick(1'b1, 1'b0, 64'd0, bub);
        set_ex(1'b0, 1'b0, 5'd0);
        tick(1'b0, 1'b1, 64'h210, mk(8'h01, 64'd0, 64'd5, 64'd4, 64'h200, 5'd4, 5'd2, 5'd2));
        set_id(1'b1, enc_r(ADD, 5'd1, 5'd2, 5'd3), 64'h204);
        tick(1'b0, 1'b0, 64'd0, bub);

        // CBZ on nonzero register: not taken
        set_id(1'b1, enc_cb(CBZ, 19'd1, 5'd2), 64'h300);
        tick(1'b0, 1'b0, 64'd0, mk(8'h01, 64'd0, 64'd5, 64'd1, 64'h300, 5'd1, 5'd2, 5'd2));

        // Load to XZR in EX is not a hazard
        set_ex(1'b1, 1'b1, 5'd31);
        set_id(1'b1, enc_r(ADD, 5'd11, 5'd31, 5'd3), 64'h310);
        tick(1'b0, 1'b0, 64'd0, mk(8'h82, 64'd0, 64'd7, 64'd0, 64'h310, 5'd31, 5'd3, 5'd11));
        set_ex(1'b0, 1'b0, 5'd0);

        // LDUR X12,[X2,#-1]; STUR X6,[X2,#8]; ADDI X13,X3,#0xFFF
        set_id(1'b1, enc_d(LDUR, 9'h1FF, 5'd2, 5'd12), 64'h320);
        tick(1'b0, 1'b0, 64'd0, mk(8'hE8, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h320, 5'd2, 5'd31, 5'd12));
        set_id(1'b1, enc_d(STUR, 9'h008, 5'd2, 5'd6), 64'h324);
        tick(1'b0, 1'b0, 64'd0, mk(8'h18, 64'd5, 64'h66, 64'd8, 64'h324, 5'd2, 5'd6, 5'd6));
        set_id(1'b1, {10'b1001000100, 12'hFFF, 5'd3, 5'd13}, 64'h328);
        tick(1'b0, 1'b0, 64'd0, mk(8'h88, 64'd7, 64'd0, 64'hFFF, 64'h328, 5'd3, 5'd31, 5'd13));

        // Unknown opcode, and invalid instruction with a would-be hazard
        set_id(1'b1, 32'd0, 64'h330);
        tick(1'b0, 1'b0, 64'd0, bub);
        set_id(1'b0, enc_r(ADD, 5'd5, 5'd4, 5'd6), 64'h334);
        set_ex(1'b1, 1'b1, 5'd4);
        tick(1'b0, 1'b0, 64'd0, bub);

        // BR X6 behind an ALU producer
        set_id(1'b1, {11'b11010110000, 5'd31, 6'd0, 5'd6, 5'd0}, 64'h340);
        set_ex(1'b1, 1'b0, 5'd6);
        tick(1'b1, 1'b0, 64'd0, bub);
        set_ex(1'b0, 1'b0, 5'd0);
        tick(1'b0, 1'b1, 64'h66, mk(8'h00, 64'h66, 64'd0, 64'd0, 64'h340, 5'd6, 5'd31, 5'd0));
        set_id(1'b1, enc_r(ADD, 5'd1, 5'd2, 5'd3), 64'h344);
        tick(1'b0, 1'b0, 64'd0, bub);

        // Reset clears a pending squash
        set_id(1'b1, enc_b(BOP, 26'd1), 64'h500);
        tick(1'b0, 1'b1, 64'h504, mk(8'h00, 64'd0, 64'd0, 64'd1, 64'h500, 5'd0, 5'd0, 5'd1));
        reset = 1'b1;
        set_id(1'b1, enc_r(ADD, 5'd1, 5'd2, 5'd3), 64'h504);
        tick(1'b0, 1'b0, 64'd0, bub);
        reset = 1'b0;
        tick(1'b0, 1'b0, 64'd0, mk(8'h82, 64'd0, 64'd0, 64'd0, 64'h504, 5'd2, 5'd3, 5'd1));

        // Reset during HOLD aborts the stall; CBZ re-evaluated fresh
        set_id(1'b1, enc_cb(CBZ, 19'd3, 5'd9), 64'h100);
        set_ex(1'b1, 1'b1, 5'd9);
        tick(1'b1, 1'b0, 64'd0, bub);
        reset = 1'b1;
        set_ex(1'b0, 1'b0, 5'd0);
        tick(1'b0, 1'b0, 64'd0, bub);
        reset = 1'b0;
        tick(1'b0, 1'b1, 64'h10C, mk(8'h01, 64'd0, 64'd0, 64'd3, 64'h100, 5'd3, 5'd9, 5'd9));
        set_id(1'b0, 32'd0, 64'd0);
        tick(1'b0, 1'b0, 64'd0, bub);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
